// File: rtl/bht_update_ctrl_if.sv
// Execute-stage record handshake and BHT write port of the BHT update sequencer.
// The slave modport is the controller's view; master is the surrounding pipeline/table.
interface bht_update_ctrl_if #(
  parameter int IDX_W = 5
);
  logic             ex_valid;
  logic             ex_ready;
  logic [IDX_W-1:0] ex_idx;
  logic             ex_taken;
  logic             ex_pred;
  logic             mispredict;
  logic             bht_wr_en;
  logic             bht_wr_ready;
  logic [IDX_W-1:0] bht_wr_addr;
  logic             bht_wr_taken;
  logic             bht_init;

  modport master (
    output ex_valid, ex_idx, ex_taken, ex_pred, bht_wr_ready,
    input  ex_ready, mispredict, bht_wr_en, bht_wr_addr, bht_wr_taken, bht_init
  );

  modport slave (
    input  ex_valid, ex_idx, ex_taken, ex_pred, bht_wr_ready,
    output ex_ready, mispredict, bht_wr_en, bht_wr_addr, bht_wr_taken, bht_init
  );
endinterface

// File: rtl/bht_update_ctrl.sv
// BHT update sequencer: init sweep, record handshake, mispredict flag, update FIFO drain.
// Optional BHT_CTRL_STATS_EN adds saturating branch/mispredict counters.
module bht_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 en,
  input  logic                 init_req,
  bht_update_ctrl_if.slave     bus,
  output logic                 busy
`ifdef BHT_CTRL_STATS_EN
  ,
  output logic [15:0]          stat_branches,
  output logic [15:0]          stat_mispred
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] CntFull = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_init_ptr;
  logic [IDX_W:0]   r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             r_mispredict;

  logic             w_ex_ready;
  logic             w_wr_en;
  logic             w_init;
  logic [IDX_W-1:0] w_addr;
  logic             w_taken;
  logic             w_busy;
  logic [IDX_W:0]   w_head;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;

  assign w_head   = r_mem[r_rd_ptr];
  assign w_accept = bus.ex_valid && w_ex_ready;
  assign w_push   = w_accept && en && !init_req;
  assign w_pop    = (r_state == RUN) && w_wr_en && bus.bht_wr_ready;
  assign w_flush  = (r_state == RUN) && init_req;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_ex_ready   = 1'b0;
    w_wr_en      = 1'b0;
    w_init       = 1'b0;
    w_addr       = '0;
    w_taken      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy       = 1'b1;
        w_next_state = INIT;
      end
      INIT: begin
        w_busy  = 1'b1;
        w_wr_en = 1'b1;
        w_init  = 1'b1;
        w_addr  = r_init_ptr;
        if (bus.bht_wr_ready && (r_init_ptr == '1)) w_next_state = RUN;
      end
      RUN: begin
        w_ex_ready = (r_count != CntFull);
        w_wr_en    = (r_count != '0);
        w_addr     = w_head[IDX_W-1:0];
        w_taken    = w_head[IDX_W];
        if (init_req) w_next_state = INIT;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The pointer wraps to 0 after the last entry, so a later sweep starts clean.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_init_ptr <= '0;
    end else if (w_flush) begin
      r_init_ptr <= '0;
    end else if ((r_state == INIT) && bus.bht_wr_ready) begin
      r_init_ptr <= r_init_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {bus.ex_taken, bus.ex_idx};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_mispredict <= 1'b0;
    else         r_mispredict <= w_accept && (bus.ex_taken ^ bus.ex_pred);
  end

  assign busy             = w_busy;
  assign bus.ex_ready     = w_ex_ready;
  assign bus.bht_wr_en    = w_wr_en;
  assign bus.bht_init     = w_init;
  assign bus.bht_wr_addr  = w_addr;
  assign bus.bht_wr_taken = w_taken;
  assign bus.mispredict   = r_mispredict;

`ifdef BHT_CTRL_STATS_EN
  logic        w_enter_init;
  logic [15:0] r_stat_branches;
  logic [15:0] r_stat_mispred;

  assign w_enter_init = (w_next_state == INIT) && (r_state != INIT);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else if (w_enter_init) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (w_accept && (r_stat_branches != 16'hFFFF))
        r_stat_branches <= r_stat_branches + 16'd1;
      if (r_mispredict && (r_stat_mispred != 16'hFFFF))
        r_stat_mispred <= r_stat_mispred + 16'd1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Scoreboard bench for bht_update_ctrl: directed records, expected writes and
// mispredict bits queued by the stimulus and checked by an independent monitor.
module tb_bht_update_ctrl;
  localparam int IDX_W = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic en = 1'b1;
  logic init_req = 1'b0;
  logic busy;
`ifdef BHT_CTRL_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispred;
`endif

  bht_update_ctrl_if #(.IDX_W(IDX_W)) bus ();

  bht_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .en            (en),
    .init_req      (init_req),
    .bus           (bus),
    .busy          (busy)
`ifdef BHT_CTRL_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0] addr;
    logic             taken;
    logic             init;
  } wr_t;

  wr_t  wq[$];
  logic mq[$];
  int   nCompared = 0;
  int   nMismatched = 0;
  logic accPrev = 1'b0;
  int   busyCycles;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: event occurred, expected none", name);
  endtask

  // Monitor: pops expected writes/mispredict bits as the DUT presents them
  always @(negedge clk) begin
    wr_t e;
    if (!arst_n) begin
      accPrev = 1'b0;
    end else begin
      if (accPrev) begin
        if (mq.size() == 0) reportFail("mispredict_no_expectation");
        else checkOutput("mispredict", bus.mispredict, mq.pop_front());
      end else begin
        checkOutput("mispredict_quiet", bus.mispredict, 1'b0);
      end
      if (bus.bht_wr_en && bus.bht_wr_ready) begin
        if (wq.size() == 0) begin
          reportFail("write_unexpected");
        end else begin
          e = wq.pop_front();
          checkOutput("wr_addr", bus.bht_wr_addr, e.addr);
          checkOutput("wr_taken", bus.bht_wr_taken, e.taken);
          checkOutput("wr_init", bus.bht_init, e.init);
        end
      end
      accPrev = bus.ex_valid && bus.ex_ready;
    end
  end

  task automatic applyStimulus(input logic [IDX_W-1:0] idx, input logic taken, input logic pred);
    bus.ex_valid = 1'b1;
    bus.ex_idx   = idx;
    bus.ex_taken = taken;
    bus.ex_pred  = pred;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.ex_ready) begin
        @(posedge clk);
        mq.push_back(taken ^ pred);
        if (en) wq.push_back(wr_t'{addr: idx, taken: taken, init: 1'b0});
        #1 bus.ex_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    reportFail("accept_timeout");
    #1 bus.ex_valid = 1'b0;
  endtask

  task automatic pushSweep();
    for (int i = 0; i < 32; i++) wq.push_back(wr_t'{addr: IDX_W'(i), taken: 1'b0, init: 1'b1});
  endtask

  task automatic waitSweep(output int cycles);
    cycles = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) begin
        checkOutput("ex_ready_after_sweep", bus.ex_ready, 1'b1);
        return;
      end
      cycles++;
    end
    reportFail("sweep_timeout");
  endtask

  task automatic checkReset();
    checkOutput("rst_busy", busy, 1'b1);
    checkOutput("rst_ex_ready", bus.ex_ready, 1'b0);
    checkOutput("rst_wr_en", bus.bht_wr_en, 1'b0);
    checkOutput("rst_init", bus.bht_init, 1'b0);
    checkOutput("rst_mispredict", bus.mispredict, 1'b0);
    checkOutput("rst_wr_addr", bus.bht_wr_addr, '0);
    checkOutput("rst_wr_taken", bus.bht_wr_taken, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.ex_valid     = 1'b0;
    bus.ex_idx       = '0;
    bus.ex_taken     = 1'b0;
    bus.ex_pred      = 1'b0;
    bus.bht_wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 checkReset();

    // Power-up sweep: IDLE cycle plus 32 init writes
    pushSweep();
    arst_n = 1'b1;
    waitSweep(busyCycles);
    checkOutput("busy_cycles_reset", busyCycles, 33);

    // Single mispredicted record appears at the write port next cycle
    @(posedge clk); #1;
    applyStimulus(5'd7, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("wr_en_next_cycle", bus.bht_wr_en, 1'b1);
    checkOutput("wr_addr_next_cycle", bus.bht_wr_addr, 5'd7);
    repeat (2) @(posedge clk); #1;

    // Backpressure: four fill the FIFO, fifth is refused
    bus.bht_wr_ready = 1'b0;
    applyStimulus(5'd1, 1'b1, 1'b1);
    applyStimulus(5'd2, 1'b0, 1'b0);
    applyStimulus(5'd3, 1'b1, 1'b0);
    applyStimulus(5'd4, 1'b0, 1'b1);
    bus.ex_valid = 1'b1;
    bus.ex_idx   = 5'd5;
    bus.ex_taken = 1'b1;
    bus.ex_pred  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("ex_ready_full", bus.ex_ready, 1'b0);
    end
    @(posedge clk); #1;
    bus.ex_valid     = 1'b0;
    bus.bht_wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("drain_consecutive", bus.bht_wr_en, 1'b1);
    end
    @(negedge clk);
    checkOutput("drain_empty", bus.bht_wr_en, 1'b0);
    @(posedge clk); #1;

    // Simultaneous push/pop at count 2 across pointer wrap
    bus.bht_wr_ready = 1'b0;
    applyStimulus(5'd10, 1'b1, 1'b1);
    applyStimulus(5'd11, 1'b0, 1'b0);
    bus.bht_wr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      applyStimulus(IDX_W'(12 + i), iv[0], iv[1]);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("steady_tail", bus.bht_wr_en, 1'b1);
    end
    @(negedge clk);
    checkOutput("steady_empty", bus.bht_wr_en, 1'b0);
    @(posedge clk); #1;

    // init_req with queued entries and a concurrent mispredicted record
    bus.bht_wr_ready = 1'b0;
    applyStimulus(5'd20, 1'b1, 1'b0);
    applyStimulus(5'd21, 1'b0, 1'b0);
    applyStimulus(5'd22, 1'b1, 1'b1);
    bus.ex_valid = 1'b1;
    bus.ex_idx   = 5'd23;
    bus.ex_taken = 1'b0;
    bus.ex_pred  = 1'b1;
    init_req     = 1'b1;
    @(negedge clk);
    checkOutput("ready_before_init", bus.ex_ready, 1'b1);
    @(posedge clk);
    mq.push_back(1'b1);
    wq.delete();
    pushSweep();
    #1;
    bus.ex_valid     = 1'b0;
    init_req         = 1'b0;
    bus.bht_wr_ready = 1'b1;
    waitSweep(busyCycles);
    checkOutput("busy_cycles_init_req", busyCycles, 32);

    // Predictor disabled: handshake and mispredict only
    @(posedge clk); #1;
    en = 1'b0;
    applyStimulus(5'd3, 1'b1, 1'b0);
    applyStimulus(5'd4, 1'b1, 1'b1);
    applyStimulus(5'd5, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("no_write_en0", bus.bht_wr_en, 1'b0);
    end
    en = 1'b1;

    // Reset in the middle of a sweep restarts it from entry 0
    @(posedge clk); #1;
    init_req = 1'b1;
    @(posedge clk);
    pushSweep();
    #1 init_req = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("sweep_ptr_before_reset", bus.bht_wr_addr, 5'd12);
    arst_n = 1'b0;
    wq.delete();
    #1 checkReset();
    @(posedge clk); #1;
    pushSweep();
    arst_n = 1'b1;
    waitSweep(busyCycles);
    checkOutput("busy_cycles_restart", busyCycles, 33);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("writes_outstanding", wq.size(), 0);
    checkOutput("mispredicts_outstanding", mq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/bht_update_ctrl.md
# bht_update_ctrl

Update sequencer for the 32-entry, 2-bit-counter branch history table. It sits between the execute stage and the BHT write port. It performs the table initialisation sweep after reset or on request. It accepts resolved-branch records through a valid/ready handshake, flags mispredictions to the pipeline, and buffers records in a 4-entry FIFO. It drains that FIFO into the BHT one update per accepted write.

## Interface
Parameters:
- `DEPTH`, 4: update FIFO entries; power of two, 2..16.
- `IDX_W`, 5: BHT index width; the table has 2**IDX_W entries.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  predictor enable; when low, records are handshaken but not queued.
- `init_req`  in  1  single-cycle request to re-initialise the table.
- `ex_valid`  in  1  resolved-branch record valid.
- `ex_ready`  out  1  controller can accept a record.
- `ex_idx`  in  IDX_W  BHT index of the resolved branch.
- `ex_taken`  in  1  actual branch outcome.
- `ex_pred`  in  1  prediction that was used at fetch.
- `mispredict`  out  1  one-cycle pulse: the accepted record had `ex_taken != ex_pred`.
- `bht_wr_en`  out  1  BHT write request.
- `bht_wr_ready`  in  1  BHT accepts the write this cycle.
- `bht_wr_addr`  out  IDX_W  BHT entry to write.
- `bht_wr_taken`  out  1  outcome applied to the counter.
- `bht_init`  out  1  the write forces the entry to 2'b01 (weakly not-taken) and ignores `bht_wr_taken`.
- `busy`  out  1  an initialisation sweep is pending or in progress.

## Operation
FSM states:
- IDLE is the reset state. Next cycle it goes unconditionally to INIT.
- INIT runs the sweep.
  - `init_ptr` starts at 0 and increments on each cycle where `bht_wr_en && bht_wr_ready`.
  - After the write to entry 2**IDX_W-1 is accepted, the FSM goes to RUN.
- RUN is normal operation. If `init_req` is high, the FSM goes to INIT: `init_ptr` is cleared and the FIFO is emptied (count := 0), so pending updates are dropped.

Outputs by state:
- IDLE: `busy`=1, `ex_ready`=0, `bht_wr_en`=0.
- INIT: `busy`=1, `ex_ready`=0, `bht_wr_en`=1, `bht_init`=1, `bht_wr_addr`=`init_ptr`, `bht_wr_taken`=0.
- RUN:
  - `busy`=0, `bht_init`=0.
  - `ex_ready` = FIFO not full.
  - `bht_wr_en` = FIFO not empty.
  - `bht_wr_addr` and `bht_wr_taken` come from the FIFO head.

Handshake and FIFO:
- A record is accepted on `ex_valid && ex_ready`.
- It is pushed only if `en`=1 and `init_req`=0.
- A pop happens on `bht_wr_en && bht_wr_ready` in RUN.
- Push and pop in the same cycle are allowed; the count is unchanged.
- Read and write pointers are log2(DEPTH) bits, wrapping modulo DEPTH. The count is log2(DEPTH)+1 bits.
- There is no same-cycle bypass: a push into an empty FIFO is visible at the BHT port the next cycle.
- `ex_ready` depends only on registered state, never on `ex_valid`.

Mispredict:
- `mispredict` is registered: next cycle it equals `accept && (ex_taken ^ ex_pred)`.
- It is independent of `en` and of `init_req`. A record accepted in the same cycle as `init_req` still reports its mispredict but is not queued.

Holding and reset:
- `en`=0 does not stall draining; records already queued are still written.
- `arst_n` low at any time returns immediately to IDLE with the FIFO empty and `init_ptr`=0. An interrupted sweep restarts from entry 0.

## Timing
Reset values:
- `busy`=1.
- `ex_ready`=0, `bht_wr_en`=0, `bht_init`=0, `mispredict`=0.
- `bht_wr_addr`=0, `bht_wr_taken`=0.

Latency:
- After reset release: IDLE lasts 1 cycle. INIT lasts 2**IDX_W cycles (32 by default) with `bht_wr_ready` held high, stretched by every cycle `bht_wr_ready` is low. The first record can be accepted in cycle 1+32 (counting the IDLE cycle as cycle 0).
- A record accepted in cycle N appears at `bht_wr_en` in cycle N+1 and `mispredict` pulses in cycle N+1.
- Sustained throughput is one update per cycle while `bht_wr_ready`=1.

## Configuration
- `BHT_CTRL_STATS_EN` defined: adds outputs `stat_branches[15:0]` and `stat_mispred[15:0]`.
  - `stat_branches` increments on every accepted record.
  - `stat_mispred` increments on every `mispredict` pulse.
  - Both saturate at 16'hFFFF and are cleared by `arst_n` and by entering INIT.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset release, `bht_wr_ready`=1: `busy`=1 for 33 cycles; addresses 0..31 each appear exactly once with `bht_init`=1; `ex_ready` rises in the cycle `busy` falls.
- Push (idx=7, taken=1, pred=0): `mispredict`=1 for exactly one cycle, and next cycle `bht_wr_en`=1 with addr=7, taken=1.
- Hold `bht_wr_ready`=0 and push 5 records: first 4 accepted, then `ex_ready`=0; release `bht_wr_ready`: 4 writes in push order on consecutive cycles.
- Simultaneous push and pop with FIFO at count 2: count stays 2 and order is preserved across pointer wrap (16 such cycles).
- `init_req` with 3 entries queued and `ex_valid`=1 (taken≠pred): `mispredict` pulses, queued entries are never written, sweep restarts at addr 0.
- `en`=0, push 3 records: no `bht_wr_en`, `mispredict` still correct; `arst_n` pulsed mid-sweep at ptr=12 → sweep restarts at 0.
